// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: show-ahead receive FIFO handshake between the UART receiver and its consumer
interface uart_rx_core_if;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    modport master (output rx_data_o, rx_valid_o, input rx_ready_i);
    modport slave  (input rx_data_o, rx_valid_o, output rx_ready_i);
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling 8N1/8E1 UART receiver feeding a small show-ahead FIFO
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           PCLK,
    input  logic           PRESET,
    input  logic           rx_i,
    uart_rx_core_if.master rx,
    output logic           frame_err_o,
    output logic           parity_err_o,
    output logic           overrun_o,
    output logic           busy_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

    state_t        state, state_n;
    logic          sync1, rxs;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    sh, sh_n;
    logic          pe, pe_n;
    logic          push, ferr_n, perr_n;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_n;
    logic          pop, wr_en, ovr_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        bit_n   = bit_cnt;
        sh_n    = sh;
        pe_n    = pe;
        push    = 1'b0;
        ferr_n  = 1'b0;
        perr_n  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxs) state_n = START;
            end
            START: if (cnt == HALF) begin
                cnt_n   = '0;
                bit_n   = '0;
                pe_n    = 1'b0;
                state_n = rxs ? IDLE : DATA;
            end
            DATA: if (cnt == LAST) begin
                cnt_n         = '0;
                sh_n[bit_cnt] = rxs;
                bit_n         = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) state_n = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: if (cnt == LAST) begin
                cnt_n   = '0;
                pe_n    = ^{sh, rxs};
                state_n = STOP;
            end
            STOP: if (cnt == LAST) begin
                // leaving at the stop midpoint lets a back-to-back start edge be caught
                cnt_n   = '0;
                ferr_n  = !rxs;
                push    = rxs && !pe;
                perr_n  = rxs && pe;
                state_n = rxs ? IDLE : BRK;
            end
            BRK: begin
                cnt_n = '0;
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign pop     = rx.rx_valid_o && rx.rx_ready_i;
    assign wr_en   = push && (count != FULL || pop);
    assign ovr_n   = push && count == FULL && !pop;
    assign count_n = count + (AW + 1)'(wr_en) - (AW + 1)'(pop);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            {sync1, rxs}  <= 2'b11;
            state         <= IDLE;
            cnt           <= '0;
            bit_cnt       <= '0;
            sh            <= '0;
            pe            <= 1'b0;
            frame_err_o   <= 1'b0;
            parity_err_o  <= 1'b0;
            overrun_o     <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            rx.rx_valid_o <= 1'b0;
        end else begin
            {sync1, rxs}  <= {rx_i, sync1};
            state         <= state_n;
            cnt           <= cnt_n;
            bit_cnt       <= bit_n;
            sh            <= sh_n;
            pe            <= pe_n;
            frame_err_o   <= ferr_n;
            parity_err_o  <= perr_n;
            overrun_o     <= ovr_n;
            wr_ptr        <= wr_ptr + AW'(wr_en);
            rd_ptr        <= rd_ptr + AW'(pop);
            count         <= count_n;
            rx.rx_valid_o <= count_n != '0;
        end
    end

    always_ff @(posedge PCLK) begin
        if (wr_en) mem[wr_ptr] <= sh;
    end

    assign rx.rx_data_o = rx.rx_valid_o ? mem[rd_ptr] : 8'h00;
    assign busy_o       = state != IDLE;
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frame vectors plus hand sequences for the UART receiver
module tb_uart_rx_core;
    logic clk, rst, rx0, rx1;
    logic ferr0, perr0, ovr0, busy0, ferr1, perr1, ovr1, busy1;
    uart_rx_core_if if0();
    uart_rx_core_if if1();

    uart_rx_core #(.CLKS_PER_BIT(16), .PARITY_EN(0), .FIFO_DEPTH(4)) u0 (
        .PCLK(clk), .PRESET(rst), .rx_i(rx0), .rx(if0),
        .frame_err_o(ferr0), .parity_err_o(perr0), .overrun_o(ovr0), .busy_o(busy0));
    uart_rx_core #(.CLKS_PER_BIT(16), .PARITY_EN(1), .FIFO_DEPTH(4)) u1 (
        .PCLK(clk), .PRESET(rst), .rx_i(rx1), .rx(if1),
        .frame_err_o(ferr1), .parity_err_o(perr1), .overrun_o(ovr1), .busy_o(busy1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_n;
        logic [7:0] exp_byte;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [6];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    int vc0 = 0, fe0 = 0, pe0 = 0, ov0 = 0, pe1 = 0, fe1 = 0;
    int s_n0, s_vc0, s_fe0, s_pe0, s_ov0, s_n1, s_pe1, s_fe1;
    int checks = 0, errors = 0;
    logic busy_seen;
    logic [7:0] b;

    always @(negedge clk) begin
        if (if0.rx_valid_o && if0.rx_ready_i) q0.push_back(if0.rx_data_o);
        if (if1.rx_valid_o && if1.rx_ready_i) q1.push_back(if1.rx_data_o);
        if (if0.rx_valid_o) vc0++;
        if (ferr0) fe0++;
        if (perr0) pe0++;
        if (ovr0) ov0++;
        if (ferr1) fe1++;
        if (perr1) pe1++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic snap();
        s_n0 = q0.size(); s_vc0 = vc0; s_fe0 = fe0; s_pe0 = pe0; s_ov0 = ov0;
        s_n1 = q1.size(); s_pe1 = pe1; s_fe1 = fe1;
    endtask

    task automatic drive(input int d, input logic v, input int n);
        if (d == 0) rx0 = v; else rx1 = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int d, input logic [7:0] data, input int par, input logic stop);
        drive(d, 1'b0, 16);
        for (int i = 0; i < 8; i++) drive(d, data[i], 16);
        if (par >= 0) drive(d, par[0], 16);
        drive(d, stop, 16);
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, " valid"}, 32'(if0.rx_valid_o), 0);
        chk({nm, " data"},  32'(if0.rx_data_o), 0);
        chk({nm, " busy"},  32'(busy0), 0);
        chk({nm, " ferr"},  32'(ferr0), 0);
        chk({nm, " perr"},  32'(perr0), 0);
        chk({nm, " ovr"},   32'(ovr0), 0);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 8'h00, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
        vecs[3] = '{8'h81, 1'b1, 1, 8'h81, 0};
        vecs[4] = '{8'h5A, 1'b0, 0, 8'h00, 1};
        vecs[5] = '{8'h3C, 1'b1, 1, 8'h3C, 0};
        rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1;
        if0.rx_ready_i = 1'b1; if1.rx_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            snap();
            send(0, vecs[i].data, -1, vecs[i].stop);
            drive(0, 1'b1, 24);
            chk($sformatf("vec%0d bytes", i), 32'(q0.size() - s_n0), 32'(vecs[i].exp_n));
            if (vecs[i].exp_n > 0) chk($sformatf("vec%0d byte", i), 32'(q0[s_n0]), 32'(vecs[i].exp_byte));
            chk($sformatf("vec%0d valid_cycles", i), 32'(vc0 - s_vc0), 32'(vecs[i].exp_n));
            chk($sformatf("vec%0d ferr", i), 32'(fe0 - s_fe0), 32'(vecs[i].exp_ferr));
            chk($sformatf("vec%0d perr", i), 32'(pe0 - s_pe0), 0);
            chk($sformatf("vec%0d ovr", i), 32'(ov0 - s_ov0), 0);
            chk($sformatf("vec%0d busy_end", i), 32'(busy0), 0);
        end

        snap();
        busy_seen = 1'b0;
        rx0 = 1'b0;
        repeat (4) begin @(negedge clk); busy_seen |= busy0; end
        rx0 = 1'b1;
        repeat (24) begin @(negedge clk); busy_seen |= busy0; end
        chk("glitch busy_rose", 32'(busy_seen), 1);
        chk("glitch busy_fell", 32'(busy0), 0);
        chk("glitch bytes", 32'(q0.size() - s_n0), 0);
        chk("glitch pulses", 32'((fe0 - s_fe0) + (pe0 - s_pe0) + (ov0 - s_ov0)), 0);

        snap();
        send(0, 8'h81, -1, 1'b0);
        drive(0, 1'b0, 40);
        drive(0, 1'b1, 20);
        chk("break ferr_mid", 32'(fe0 - s_fe0), 1);
        send(0, 8'h3C, -1, 1'b1);
        drive(0, 1'b1, 24);
        chk("break ferr", 32'(fe0 - s_fe0), 1);
        chk("break bytes", 32'(q0.size() - s_n0), 1);
        chk("break byte", 32'(q0[s_n0]), 32'h3C);

        snap();
        if0.rx_ready_i = 1'b0;
        for (int i = 1; i <= 5; i++) send(0, 8'(i), -1, 1'b1);
        drive(0, 1'b1, 24);
        chk("ovr pulses", 32'(ov0 - s_ov0), 1);
        chk("ovr hold_valid", 32'(if0.rx_valid_o), 1);
        chk("ovr hold_data", 32'(if0.rx_data_o), 32'h01);
        chk("ovr no_pop", 32'(q0.size() - s_n0), 0);
        if0.rx_ready_i = 1'b1;
        repeat (10) @(negedge clk);
        chk("ovr drained", 32'(q0.size() - s_n0), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("ovr order%0d", i), 32'(q0[s_n0 + i]), 32'(i + 1));
        chk("ovr empty", 32'(if0.rx_valid_o), 0);

        snap();
        send(1, 8'h0F, 1, 1'b1);
        drive(1, 1'b1, 24);
        chk("par perr", 32'(pe1 - s_pe1), 1);
        chk("par bad_bytes", 32'(q1.size() - s_n1), 0);
        send(1, 8'h0F, 0, 1'b1);
        drive(1, 1'b1, 24);
        chk("par perr_total", 32'(pe1 - s_pe1), 1);
        chk("par ferr", 32'(fe1 - s_fe1), 0);
        chk("par bytes", 32'(q1.size() - s_n1), 1);
        chk("par byte", 32'(q1[s_n1]), 32'h0F);

        snap();
        b = 8'h5A;
        drive(0, 1'b0, 16);
        for (int i = 0; i < 4; i++) drive(0, b[i], 16);
        rx0 = b[4];
        repeat (8) @(negedge clk);
        chk("rst busy_before", 32'(busy0), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("midrst");
        rst = 1'b0;
        rx0 = 1'b1;
        repeat (30) @(negedge clk);
        chk("midrst bytes", 32'(q0.size() - s_n0), 0);
        chk("midrst pulses", 32'((fe0 - s_fe0) + (pe0 - s_pe0) + (ov0 - s_ov0)), 0);
        send(0, 8'h5A, -1, 1'b1);
        drive(0, 1'b1, 24);
        chk("midrst next_bytes", 32'(q0.size() - s_n0), 1);
        chk("midrst next_byte", 32'(q0[s_n0]), 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
